// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Optional trailing even-parity bit is built in when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             last_bit,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par_q, par_d;
`else
    localparam bit PAR_EN = 1'b0;
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d, sv_q, sv_d, fs_q, fs_d, lb_q, lb_d;
    logic             last_data, hs;

    // cnt_q is the index of the bit currently presented on serial_out
    assign last_data = (state_q == SHIFT) && (cnt_q == CW'(WIDTH-1));

`ifdef PISO_PARITY_EN
    assign load_ready = !rst && (state_q == IDLE || state_q == PARITY);
`else
    assign load_ready = !rst && (state_q == IDLE || last_data);
`endif

    assign hs = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        so_d    = 1'b0;
        sv_d    = 1'b0;
        fs_d    = 1'b0;
        lb_d    = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (hs) begin
            state_d = SHIFT;
            cnt_d   = '0;
            so_d    = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            shreg_d = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
            sv_d    = 1'b1;
            fs_d    = 1'b1;
`ifdef PISO_PARITY_EN
            par_d   = ^data_in;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!last_data) begin
                        cnt_d   = cnt_q + 1'b1;
                        so_d    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        sv_d    = 1'b1;
                        lb_d    = !PAR_EN && (cnt_q == CW'(WIDTH-2));
                    end else begin
                        cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
                        so_d    = par_q;
                        sv_d    = 1'b1;
                        lb_d    = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            lb_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            sv_q    <= sv_d;
            fs_q    <= fs_d;
            lb_q    <= lb_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign serial_out   = so_q;
    assign serial_valid = sv_q;
    assign frame_start  = fs_q;
    assign last_bit     = lb_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus; directed table plus
// randomized traffic checked against a per-cycle expected-bit queue model.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = '0;
    logic       load_valid = 1'b0;
    logic       rdy_m, so_m, sv_m, fs_m, lb_m, busy_m;
    logic       rdy_l, so_l, sv_l, fs_l, lb_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy_m), .serial_out(so_m), .serial_valid(sv_m),
        .frame_start(fs_m), .last_bit(lb_m), .busy(busy_m));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy_l), .serial_out(so_l), .serial_valid(sv_l),
        .frame_start(fs_l), .last_bit(lb_l), .busy(busy_l));

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic b;
        logic fs;
        logic lb;
    } ent_t;

    typedef struct {
        logic       r;
        logic       lv;
        logic [3:0] d;
        logic       so;
        logic       sol;
        logic       sv;
        logic       fs;
        logic       lb;
        logic       rdy;
    } vec_t;

    ent_t qm[$];
    ent_t ql[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    logic hs_m, hs_l;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic lv, input logic [3:0] d,
                               input logic so, input logic sol, input logic sv,
                               input logic fs, input logic lb, input logic rdy);
        vec_t t;
        t.r = r; t.lv = lv; t.d = d; t.so = so; t.sol = sol;
        t.sv = sv; t.fs = fs; t.lb = lb; t.rdy = rdy;
        return t;
    endfunction

    // A frame is just the ordered list of bits it will put on the line
    task automatic push_frame(input logic [3:0] d, input bit msb, inout ent_t q[$]);
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            e.b  = msb ? d[3-i] : d[i];
            e.fs = (i == 0);
            e.lb = (i == 3) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.b = ^d; e.fs = 1'b0; e.lb = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic cmp_one(input string tag, input ent_t q[$], input logic so, input logic sv,
                           input logic fs, input logic lb, input logic rdy, input logic bsy);
        ent_t e;
        e = '{1'b0, 1'b0, 1'b0};
        if (q.size() > 0) e = q[0];
        chk({tag, "_serial_out"}, so, e.b);
        chk({tag, "_serial_valid"}, sv, q.size() > 0);
        chk({tag, "_frame_start"}, fs, e.fs);
        chk({tag, "_last_bit"}, lb, e.lb);
        chk({tag, "_busy"}, bsy, q.size() > 0);
        chk({tag, "_load_ready"}, rdy, !rst && q.size() <= 1);
    endtask

    task automatic drive(input logic r, input logic lv, input logic [3:0] d);
        @(negedge clk);
        rst = r; load_valid = lv; data_in = d;
        #1;
        cmp_one("msb", qm, so_m, sv_m, fs_m, lb_m, rdy_m, busy_m);
        cmp_one("lsb", ql, so_l, sv_l, fs_l, lb_l, rdy_l, busy_l);
        hs_m = !r && lv && (qm.size() <= 1);
        hs_l = !r && lv && (ql.size() <= 1);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (hs_m) push_frame(data_in, 1'b1, qm);
            if (hs_l) push_frame(data_in, 1'b0, ql);
        end
    endtask

    initial begin
`ifdef PISO_PARITY_EN
        tbl.push_back(v(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1));
`else
        tbl.push_back(v(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 1, 1));
        // back-to-back 1100 then 0110
        tbl.push_back(v(0, 1, 4'b1100, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 4'b0110, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 4'b0110, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 4'b0110, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 4'b0110, 0, 1, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 4'b0000, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 0, 0, 1, 0, 1, 1));
        // load while busy is ignored
        tbl.push_back(v(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 4'b0000, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1));
        // reset mid-frame, then a fresh load
        tbl.push_back(v(0, 1, 4'b1111, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 4'b0000, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 4'b0101, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 4'b0000, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 4'b0000, 1, 0, 1, 0, 1, 1));
        tbl.push_back(v(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1));
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].lv, tbl[i].d);
            chk($sformatf("tbl%0d_serial_out", i), so_m, tbl[i].so);
            chk($sformatf("tbl%0d_serial_out_lsb", i), so_l, tbl[i].sol);
            chk($sformatf("tbl%0d_serial_valid", i), sv_m, tbl[i].sv);
            chk($sformatf("tbl%0d_frame_start", i), fs_m, tbl[i].fs);
            chk($sformatf("tbl%0d_last_bit", i), lb_m, tbl[i].lb);
            chk($sformatf("tbl%0d_load_ready", i), rdy_m, tbl[i].rdy);
            advance();
        end

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 4'($urandom));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 4-bit SIPO shift register and drives its serial input.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clock.
- Supports gapless back-to-back frames and flags the first and last bit of each frame.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  serializer can accept a word this cycle.
- serial_out  output  1  serial data bit, registered.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of each frame.
- last_bit  output  1  high with the final bit of each frame.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - On that edge: state = IDLE; shift register and bit counter cleared.
  - serial_out, serial_valid, frame_start, last_bit and busy all = 0.
  - load_ready = 0 while rst is high.
- State machine: IDLE, SHIFT, PARITY (PARITY exists only with the optional feature).
- Handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - load_valid while load_ready = 0 is ignored; data_in is not sampled.
  - data_in may change freely when not handshaking.
- load_ready (combinational from state):
  - 1 in IDLE.
  - 1 in the final serial cycle of a frame (SHIFT with last_bit, or PARITY).
  - 0 otherwise.
- Latency: a word accepted at edge N appears on serial_out starting at the cycle after edge N.
  - All serial outputs are registered.
  - A frame occupies exactly WIDTH consecutive cycles of serial_valid = 1.
- SHIFT: one bit per cycle in MSB_FIRST order; the bit counter runs 0..WIDTH-1.
  - frame_start = 1 when the counter is 0.
  - last_bit = 1 when the counter is WIDTH-1.
- IDLE -> SHIFT on handshake.
- SHIFT with last_bit:
  - With a handshake in the same cycle, the next frame starts on the following cycle. No idle gap; frame_start follows last_bit directly.
  - Without a handshake, return to IDLE.
- IDLE outputs: serial_out = 0, serial_valid = 0, busy = 0.
- Reset mid-frame: the frame is aborted with no last_bit pulse. The first post-reset cycle behaves as idle.
- No wrap-around: the counter never exceeds WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, the FSM enters PARITY for one cycle.
  - serial_out = XOR of all data bits (even parity); serial_valid = 1.
  - last_bit moves to the parity cycle; the final data bit no longer asserts last_bit.
  - Frame length is WIDTH+1; load_ready = 1 only during PARITY (and IDLE).
- Undefined: the PARITY state and its logic are absent; frames are WIDTH bits.

Test Plan:
- WIDTH=4, MSB_FIRST=1: reset, then hold load_valid=1 with data_in=4'b1011 for one cycle.
  - Next 4 cycles: serial_out = 1,0,1,1; serial_valid = 1.
  - frame_start on cycle 1; last_bit on cycle 4.
  - Then IDLE: serial_out = 0, load_ready = 1.
  - A downstream SIPO then holds parallel_out = 1011.
- MSB_FIRST=0, data_in=4'b1011 -> serial_out = 1,1,0,1.
- Back-to-back: load 4'b1100, then keep load_valid=1 with 4'b0110 offered during last_bit.
  - Required: 8 contiguous valid cycles: 1,1,0,0,0,1,1,0.
  - frame_start follows last_bit directly.
- Busy rejection: while the frame for 4'b1011 is on bit 2, pulse load_valid with 4'b0000.
  - Pulse is ignored; frame completes as 1,0,1,1; no extra frame follows.
- Reset mid-frame: assert rst during bit 2 of 4'b1111.
  - Next cycle: all outputs 0, no last_bit.
  - After release: load_ready = 1, and a new load of 4'b0101 gives 0,1,0,1.
- PISO_PARITY_EN defined, data_in=4'b1011 -> serial 1,0,1,1 then parity 1.
  - last_bit only on the 5th cycle; load_ready during the 5th cycle only.
